// File: rtl/cache_pkg.sv
// Shared types and constants for the two-requester main-memory port arbiter.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  localparam int DEF_WAIT_CYCLES = 4;
  localparam int REQ_ICACHE      = 0;
  localparam int REQ_DCACHE      = 1;

  // Round-robin pick: with both pending the requester not served last wins.
  function automatic logic rr_grant(input logic [1:0] pend, input logic last);
    if (&pend) return ~last;
    return pend[1];
  endfunction
endpackage

// File: rtl/mem_arb_req_slot.sv
// One requester's slot: pending flag plus captured rw/addr/wdata, with set-over-clear.
module mem_arb_req_slot #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          strobe_i,
  input  logic          rw_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          clr_i,
  output logic          pending_o,
  output logic          rw_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o
);
  logic          pending_q, pending_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          load;

  // A strobe landing in the owner's completion cycle is accepted as a new request.
  assign load = strobe_i && (!pending_q || clr_i);

  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d = 1'b0;
    if (load)  pending_d = 1'b1;
  end

  always_comb begin
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (load) begin
      rw_d    = rw_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) pending_q <= 1'b0;
    else        pending_q <= pending_d;
  end

  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign pending_o = pending_q;
  assign rw_o      = rw_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the I-cache and D-cache.
module mem_port_arbiter
  import cache_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int CW          = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_strobe,
  input  logic [1:0]          req_rw,
  input  logic [1:0][AW-1:0]  req_addr,
  input  logic [1:0][DW-1:0]  req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0][DW-1:0]  req_rdata,
  output logic                mem_strobe,
  output logic                mem_rw,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  output logic                busy
);
  arb_state_t          state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mrw_q, mrw_d;
  logic [AW-1:0]       maddr_q, maddr_d;
  logic [DW-1:0]       mwd_q, mwd_d;
  logic [1:0][DW-1:0]  rdata_q, rdata_d;

  logic [1:0]          pend, s_rw, clr;
  logic [1:0][AW-1:0]  s_addr;
  logic [1:0][DW-1:0]  s_wd;
  logic                grant;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    mem_arb_req_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .strobe_i (req_strobe[g]),
      .rw_i     (req_rw[g]),
      .addr_i   (req_addr[g]),
      .wdata_i  (req_wdata[g]),
      .clr_i    (clr[g]),
      .pending_o(pend[g]),
      .rw_o     (s_rw[g]),
      .addr_o   (s_addr[g]),
      .wdata_o  (s_wd[g])
    );
  end

  assign grant = rr_grant(pend, last_q);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    mrw_d      = mrw_q;
    maddr_d    = maddr_q;
    mwd_d      = mwd_q;
    rdata_d    = rdata_q;
    clr        = 2'b00;
    req_ready  = 2'b00;
    mem_strobe = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      IDLE: if (|pend) begin
        // Memory-side fields are latched here so they stay frozen until the next grant.
        owner_d = grant;
        mrw_d   = s_rw[grant];
        maddr_d = s_addr[grant];
        mwd_d   = s_wd[grant];
        state_d = ISSUE;
      end
      ISSUE: begin
        mem_strobe = 1'b1;
        cnt_d      = CW'(WAIT_CYCLES);
        state_d    = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        req_ready[owner_q] = 1'b1;
        clr[owner_q]       = 1'b1;
        last_d             = owner_q;
        if (!mrw_q) rdata_d[owner_q] = mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is forwarded during the ready cycle and held in rdata_q afterwards.
  always_comb begin
    for (int i = 0; i < 2; i++)
      req_rdata[i] = (req_ready[i] && !mrw_q) ? mem_rdata : rdata_q[i];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      mrw_q   <= 1'b0;
      maddr_q <= '0;
      mwd_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      mrw_q   <= mrw_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_rw    = mrw_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwd_q;
endmodule
